// File: rtl/alu_pipe_param_if.sv
// Handshake bundle for alu_pipe_param: operand issue side and result sink side.
interface alu_pipe_param_if #(
   parameter int WIDTH = 8
);
   logic                   in_valid;
   logic                   in_ready;
   logic [2:0]             opcode;
   logic [WIDTH-1:0]       a;
   logic [WIDTH-1:0]       b;
   logic                   out_valid;
   logic                   out_ready;
   logic [2*WIDTH-1:0]     result;
   logic                   zero;
   logic                   ovf;

   // Issue stage / sink view.
   modport master (
      output in_valid, opcode, a, b, out_ready,
      input  in_ready, out_valid, result, zero, ovf
   );

   // ALU view.
   modport slave (
      input  in_valid, opcode, a, b, out_ready,
      output in_ready, out_valid, result, zero, ovf
   );
endinterface

// File: rtl/alu_pipe_param.sv
// Parametrised signed ALU with a single-entry output register and an
// iterative shift-add signed multiplier (one partial product per cycle).
module alu_pipe_param #(
   parameter int WIDTH = 8,
   parameter bit SAT   = 1'b0
) (
   input  logic            clk,
   input  logic            reset,
   alu_pipe_param_if.slave bus
);
   localparam int W2 = 2 * WIDTH;
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
   localparam logic [CW-1:0] CNT_DONE = CW'(WIDTH);

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_NOT = 3'd2;
   localparam logic [2:0] OP_ORB = 3'd3;
   localparam logic [2:0] OP_AND = 3'd4;
   localparam logic [2:0] OP_XOR = 3'd5;
   localparam logic [2:0] OP_MUL = 3'd6;
   localparam logic [2:0] OP_SLT = 3'd7;

   // Clamp bounds of the WIDTH-bit signed range, sign-extended to W2.
   localparam logic [W2-1:0] SAT_MAX = {{(W2-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
   localparam logic [W2-1:0] SAT_MIN = {{(W2-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

   typedef enum logic {IDLE, MUL} state_t;

   state_t            state;
   logic              out_valid_q;
   logic [W2-1:0]     result_q;
   logic              zero_q;
   logic              ovf_q;

   logic [W2-1:0]     ma;        // multiplicand, shifted left each step
   logic [WIDTH-1:0]  mb;        // multiplier, shifted right each step
   logic [W2-1:0]     acc;
   logic [CW-1:0]     cnt;

   logic [W2-1:0]     ae, be, sum, alu_res, pp, acc_nxt;
   logic              alu_ovf;
   logic              accept;

   assign bus.in_ready  = (state == IDLE) & (~out_valid_q | bus.out_ready);
   assign bus.out_valid = out_valid_q;
   assign bus.result    = result_q;
   assign bus.zero      = zero_q;
   assign bus.ovf       = ovf_q;
   assign accept        = bus.in_valid & bus.in_ready;

   assign ae  = {{WIDTH{bus.a[WIDTH-1]}}, bus.a};
   assign be  = {{WIDTH{bus.b[WIDTH-1]}}, bus.b};
   assign sum = (bus.opcode == OP_SUB) ? ae - be : ae + be;

   // Single-cycle ops; overflow means the upper bits are not a sign extension of bit WIDTH-1.
   always_comb begin
      alu_res = '0;
      alu_ovf = 1'b0;
      case (bus.opcode)
         OP_ADD, OP_SUB: begin
            alu_ovf = ~((&sum[W2-1:WIDTH-1]) | ~(|sum[W2-1:WIDTH-1]));
            alu_res = sum;
            if (SAT && alu_ovf) alu_res = sum[W2-1] ? SAT_MIN : SAT_MAX;
         end
         OP_NOT:  alu_res = ~ae;
         OP_ORB:  alu_res = {{(W2-1){1'b0}}, |bus.b};
         OP_AND:  alu_res = ae & be;
         OP_XOR:  alu_res = ae ^ be;
         OP_SLT:  alu_res = {{(W2-1){1'b0}}, ($signed(bus.a) < $signed(bus.b))};
         default: alu_res = '0;
      endcase
   end

   // Two's complement multiplier: the sign bit of b carries negative weight, so the last partial product is subtracted.
   assign pp      = mb[0] ? ma : '0;
   assign acc_nxt = (cnt == CNT_LAST) ? acc - pp : acc + pp;

   // Control FSM, multiplier datapath and output register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         out_valid_q <= 1'b0;
         result_q    <= '0;
         zero_q      <= 1'b0;
         ovf_q       <= 1'b0;
         ma          <= '0;
         mb          <= '0;
         acc         <= '0;
         cnt         <= '0;
      end else begin
         if (out_valid_q && bus.out_ready) out_valid_q <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  if (bus.opcode == OP_MUL) begin
                     ma    <= ae;
                     mb    <= bus.b;
                     acc   <= '0;
                     cnt   <= '0;
                     state <= MUL;
                  end else begin
                     result_q    <= alu_res;
                     zero_q      <= (alu_res == '0);
                     ovf_q       <= alu_ovf;
                     out_valid_q <= 1'b1;
                  end
               end
            end
            MUL: begin
               if (cnt != CNT_DONE) begin
                  acc <= acc_nxt;
                  ma  <= ma << 1;
                  mb  <= mb >> 1;
                  cnt <= cnt + 1'b1;
               end else if (!out_valid_q || bus.out_ready) begin
                  result_q    <= acc;
                  zero_q      <= (acc == '0);
                  ovf_q       <= 1'b0;
                  out_valid_q <= 1'b1;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_pipe_param.sv
// Directed bench for alu_pipe_param (WIDTH=4): scoreboard of expected beats
// pushed at accept, popped by a monitor when the sink takes a result.
module tb_alu_pipe_param;
   localparam int W  = 4;
   localparam int W2 = 2 * W;
   localparam int MAXV = (1 << (W-1)) - 1;
   localparam int MINV = -(1 << (W-1));

   localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, NOT = 3'd2, ORB = 3'd3;
   localparam logic [2:0] AND = 3'd4, XOR = 3'd5, MUL = 3'd6, SLT = 3'd7;

   logic clk = 1'b0;
   logic reset;
   logic in_valid, out_ready;
   logic [2:0] opcode;
   logic [W-1:0] a, b;

   always #5 clk = ~clk;

   alu_pipe_param_if #(.WIDTH(W)) bus ();
   alu_pipe_param_if #(.WIDTH(W)) bus_s ();

   assign bus.in_valid    = in_valid;
   assign bus.opcode      = opcode;
   assign bus.a           = a;
   assign bus.b           = b;
   assign bus.out_ready   = out_ready;
   assign bus_s.in_valid  = in_valid;
   assign bus_s.opcode    = opcode;
   assign bus_s.a         = a;
   assign bus_s.b         = b;
   assign bus_s.out_ready = out_ready;

   alu_pipe_param #(.WIDTH(W), .SAT(1'b0)) dut   (.clk(clk), .reset(reset), .bus(bus));
   alu_pipe_param #(.WIDTH(W), .SAT(1'b1)) dut_s (.clk(clk), .reset(reset), .bus(bus_s));

   typedef struct packed {
      logic [W2-1:0] res;
      logic          zero;
      logic          ovf;
   } exp_t;

   exp_t q[$];
   int checks = 0;
   int errors = 0;
   int last_wait;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference model, integer arithmetic on sign-extended operands (SAT=0).
   function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] av, input logic [W-1:0] bv);
      int   sa, sb, r;
      bit   ov;
      exp_t e;
      sa = $signed(av);
      sb = $signed(bv);
      ov = 1'b0;
      case (op)
         ADD:     r = sa + sb;
         SUB:     r = sa - sb;
         NOT:     r = -sa - 1;
         ORB:     r = (bv != 0) ? 1 : 0;
         AND:     r = sa & sb;
         XOR:     r = sa ^ sb;
         MUL:     r = sa * sb;
         default: r = (sa < sb) ? 1 : 0;
      endcase
      if (op == ADD || op == SUB) ov = (r > MAXV) || (r < MINV);
      e.res  = r[W2-1:0];
      e.zero = (e.res == '0);
      e.ovf  = ov;
      return e;
   endfunction

   // Present one op at the first negedge with in_ready high; accept happens at the next posedge.
   task automatic issue(input logic [2:0] op, input logic [W-1:0] av, input logic [W-1:0] bv, input bit track);
      int n;
      n = 0;
      @(negedge clk);
      while (!bus.in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      last_wait = n;
      chk("issue_ready", bus.in_ready, 1'b1);
      in_valid = 1'b1;
      opcode   = op;
      a        = av;
      b        = bv;
      @(posedge clk);
      if (track) q.push_back(model(op, av, bv));
      #1 in_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (q.size() != 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("queue_drained", q.size(), 0);
   endtask

   // Result monitor: every delivered beat must match the oldest expectation.
   always @(negedge clk) begin
      exp_t e;
      if (!reset && bus.out_valid && bus.out_ready) begin
         if (q.size() == 0) begin
            chk("unexpected_beat", bus.out_valid, 1'b0);
         end else begin
            e = q.pop_front();
            chk("result", bus.result, e.res);
            chk("zero", bus.zero, e.zero);
            chk("ovf", bus.ovf, e.ovf);
         end
      end
   end

   initial begin
      reset     = 1'b1;
      in_valid  = 1'b0;
      opcode    = '0;
      a         = '0;
      b         = '0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;

      // Reset state
      @(negedge clk);
      chk("rst_out_valid", bus.out_valid, 1'b0);
      chk("rst_result", bus.result, 0);
      chk("rst_zero", bus.zero, 1'b0);
      chk("rst_ovf", bus.ovf, 1'b0);
      chk("rst_in_ready", bus.in_ready, 1'b1);

      // ADD overflow, plain and saturating
      issue(ADD, 4'd7, 4'd7, 1'b1);
      @(negedge clk);
      chk("sat_valid", bus_s.out_valid, 1'b1);
      chk("sat_result", bus_s.result, 8'd7);
      chk("sat_ovf", bus_s.ovf, 1'b1);
      chk("sat_zero", bus_s.zero, 1'b0);

      // SUB to zero, NOT, ORB
      issue(SUB, 4'h8, 4'h8, 1'b1);
      issue(NOT, 4'h0, 4'h0, 1'b1);
      issue(ORB, 4'h0, 4'h8, 1'b1);
      wait_drain();

      // MUL corner: timing and full-precision product
      issue(MUL, 4'h8, 4'h8, 1'b1);
      for (int k = 1; k <= W + 1; k++) begin
         @(negedge clk);
         if (k <= W) chk("mul_in_ready", bus.in_ready, 1'b0);
         chk("mul_busy_valid", bus.out_valid, 1'b0);
      end
      @(negedge clk);
      chk("mul_out_valid", bus.out_valid, 1'b1);
      issue(MUL, 4'd7, 4'hD, 1'b1);
      wait_drain();

      // Back-to-back single-cycle ops
      issue(ADD, 4'hD, 4'h5, 1'b1);
      issue(XOR, 4'h6, 4'hA, 1'b1);
      chk("b2b_wait_xor", last_wait, 0);
      issue(SLT, 4'hE, 4'h1, 1'b1);
      chk("b2b_wait_slt", last_wait, 0);
      @(negedge clk);
      chk("b2b_third_valid", bus.out_valid, 1'b1);
      wait_drain();

      // Backpressure hold
      @(posedge clk);
      #1 out_ready = 1'b0;
      issue(ADD, 4'd3, 4'd2, 1'b1);
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         chk("bp_valid", bus.out_valid, 1'b1);
         chk("bp_result", bus.result, 8'd5);
         chk("bp_in_ready", bus.in_ready, 1'b0);
      end
      @(posedge clk);
      #1 out_ready = 1'b1;
      @(negedge clk);
      chk("bp_drain_ready", bus.in_ready, 1'b1);
      @(negedge clk);
      chk("bp_after_valid", bus.out_valid, 1'b0);
      chk("bp_after_ready", bus.in_ready, 1'b1);
      wait_drain();

      // Reset during the second MUL cycle discards the op
      issue(MUL, 4'd5, 4'd3, 1'b0);
      @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("midrst_valid", bus.out_valid, 1'b0);
      chk("midrst_result", bus.result, 0);
      chk("midrst_in_ready", bus.in_ready, 1'b1);
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         chk("midrst_no_stale", bus.out_valid, 1'b0);
      end

      chk("queue_empty", q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
